// File: rtl/super_pkg.sv
// super_pkg: shared pipeline types; ir_reg_t carries a fetched instruction plus its prediction.
package super_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ptaken;
        logic [31:0] ptarget;
    } ir_reg_t;

    // Bubble: zero pc, canonical nop (addi x0,x0,0), not taken.
    localparam ir_reg_t NULL_IR_REG = '{pc: 32'h0, instr: 32'h0000_0013, ptaken: 1'b0, ptarget: 32'h0};

endpackage

// File: rtl/ir_fifo.sv
// ir_fifo: two-wide in-order instruction queue between branch prediction and decode.
//   clk_i, rst_ni (async, active-low), flush_i (EX redirect, drops all contents)
//   pdt_valid_i/pdt_instr0_i/pdt_instr1_i : up to two predicted instructions in (00/01/11)
//   ds_rdy_o    : [0] >=1 free entry, [1] >=2 free entries (back to predictor)
//   ir_valid_o/ir_instr0_o/ir_instr1_o : oldest two entries to decode
//   ir_accept_i : decode consumes entries (00/01/11)
//   occupancy_o : current entry count
// Optional: IR_FIFO_BYPASS_EN gives zero-latency pass-through while the queue is empty.
module ir_fifo
    import super_pkg::*;
#(
    parameter int Depth = 4,
    localparam int PtrW = $clog2(Depth)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic [1:0]    pdt_valid_i,
    input  ir_reg_t       pdt_instr0_i,
    input  ir_reg_t       pdt_instr1_i,
    output logic [1:0]    ds_rdy_o,
    output logic [1:0]    ir_valid_o,
    output ir_reg_t       ir_instr0_o,
    output ir_reg_t       ir_instr1_o,
    input  logic [1:0]    ir_accept_i,
    output logic [PtrW:0] occupancy_o
);

    localparam logic [PtrW:0] FULL = (PtrW+1)'(Depth);
    localparam logic [PtrW:0] LIM2 = (PtrW+1)'(Depth-2);
    localparam logic [PtrW:0] TWO  = (PtrW+1)'(2);

    ir_reg_t         mem [Depth];
    logic [PtrW-1:0] rd_ptr, wr_ptr;
    logic [PtrW:0]   count;
    logic [1:0]      pv, acc, push, pop, n_push, n_pop, n_wr, n_rd;
    logic            bypass, we0, we1;
    ir_reg_t         w0;

    always_comb begin
        // The illegal pattern 10 is treated as 00.
        pv = (pdt_valid_i == 2'b10) ? 2'b00 : pdt_valid_i;
        acc = (ir_accept_i == 2'b10) ? 2'b00 : ir_accept_i;
        ds_rdy_o = {count <= LIM2, count != FULL};
`ifdef IR_FIFO_BYPASS_EN
        bypass = (count == '0) && !flush_i;
`else
        bypass = 1'b0;
`endif
        ir_valid_o = bypass ? pv : {count >= TWO, count != '0};
        push = pv & ds_rdy_o;
        pop = acc & ir_valid_o;
        n_push = {1'b0, push[0]} + {1'b0, push[1]};
        n_pop = {1'b0, pop[0]} + {1'b0, pop[1]};
        // On bypass, instructions decode took this cycle never enter storage:
        // the unaccepted remainder shifts down to slot 0 and rd_ptr stays put.
        n_wr = bypass ? n_push - n_pop : n_push;
        n_rd = bypass ? 2'd0 : n_pop;
        we0 = n_wr != 2'd0;
        we1 = n_wr == 2'd2;
        w0 = (bypass && pop[0]) ? pdt_instr1_i : pdt_instr0_i;
        ir_instr0_o = bypass ? pdt_instr0_i : mem[rd_ptr];
        ir_instr1_o = bypass ? pdt_instr1_i : mem[rd_ptr + PtrW'(1)];
        occupancy_o = count;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            for (int i = 0; i < Depth; i++) mem[i] <= NULL_IR_REG;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (we0) mem[wr_ptr] <= w0;
            if (we1) mem[wr_ptr + PtrW'(1)] <= pdt_instr1_i;
            wr_ptr <= wr_ptr + PtrW'(n_wr);
            rd_ptr <= rd_ptr + PtrW'(n_rd);
            count <= count + (PtrW+1)'(n_push) - (PtrW+1)'(n_pop);
        end
    end

    a_pdt_valid_legal: assert property (@(posedge clk_i) disable iff (!rst_ni) pdt_valid_i != 2'b10);
    a_accept_legal:    assert property (@(posedge clk_i) disable iff (!rst_ni) ir_accept_i != 2'b10);

endmodule

// File: tb/tb_ir_fifo.sv
// tb_ir_fifo: directed self-checking bench for ir_fifo (Depth=4).
module tb_ir_fifo;
  import super_pkg::*;
  logic clk_i = 1'b0;
  logic rst_ni, flush_i;
  logic [1:0] pdt_valid_i, ir_accept_i, ds_rdy_o, ir_valid_o;
  ir_reg_t pdt_instr0_i, pdt_instr1_i, ir_instr0_o, ir_instr1_o;
  logic [2:0] occupancy_o;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q[$];
  logic [31:0] tmp[$];
  logic [31:0] next_pc;
  logic [1:0] pvv, rdy, vexp, accv, pushm;
  int sz, npush, npop;

  ir_fifo #(.Depth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .pdt_valid_i(pdt_valid_i), .pdt_instr0_i(pdt_instr0_i), .pdt_instr1_i(pdt_instr1_i),
    .ds_rdy_o(ds_rdy_o), .ir_valid_o(ir_valid_o),
    .ir_instr0_o(ir_instr0_o), .ir_instr1_o(ir_instr1_o),
    .ir_accept_i(ir_accept_i), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string t, input logic [127:0] o, input logic [127:0] e);
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask

  function automatic ir_reg_t mk(input logic [31:0] pc);
    ir_reg_t r;
    r.pc = pc;
    r.instr = {pc[15:0], 16'h0013};
    r.ptaken = pc[2];
    r.ptarget = pc + 32'h80;
    return r;
  endfunction

  task automatic drive(input logic f, input logic [1:0] pv, input logic [31:0] pc, input logic [1:0] acc);
    flush_i = f;
    pdt_valid_i = pv;
    pdt_instr0_i = mk(pc);
    pdt_instr1_i = mk(pc + 32'd4);
    ir_accept_i = acc;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 2'b00);
    #12;
    chk("rst_ds_rdy", ds_rdy_o, 2'b11);
    chk("rst_valid", ir_valid_o, 2'b00);
    chk("rst_occ", occupancy_o, 3'd0);
    chk("rst_instr0", ir_instr0_o, NULL_IR_REG);
    chk("rst_instr1", ir_instr1_o, NULL_IR_REG);
    rst_ni = 1'b1;
    tick();
    drive(1'b0, 2'b11, 32'h100, 2'b00);
    tick();
    drive(1'b0, 2'b00, 32'h0, 2'b00);
    @(negedge clk_i);
    chk("p2_valid", ir_valid_o, 2'b11);
    chk("p2_instr0", ir_instr0_o, mk(32'h100));
    chk("p2_instr1", ir_instr1_o, mk(32'h104));
    chk("p2_occ", occupancy_o, 3'd2);
    chk("p2_ds_rdy", ds_rdy_o, 2'b11);
    tick();
    drive(1'b0, 2'b11, 32'h108, 2'b00);
    tick();
    drive(1'b0, 2'b11, 32'h200, 2'b00);
    @(negedge clk_i);
    chk("full_ds_rdy", ds_rdy_o, 2'b00);
    chk("full_occ", occupancy_o, 3'd4);
    tick();
    drive(1'b0, 2'b00, 32'h0, 2'b11);
    @(negedge clk_i);
    chk("full_hold_occ", occupancy_o, 3'd4);
    chk("full_hold_pc0", ir_instr0_o.pc, 32'h100);
    chk("full_pop_ds_rdy", ds_rdy_o, 2'b00);
    tick();
    drive(1'b0, 2'b00, 32'h0, 2'b00);
    @(negedge clk_i);
    chk("after_pop_ds_rdy", ds_rdy_o, 2'b11);
    chk("after_pop_occ", occupancy_o, 3'd2);
    chk("after_pop_pc0", ir_instr0_o.pc, 32'h108);
    chk("after_pop_pc1", ir_instr1_o.pc, 32'h10c);
    tick();
    drive(1'b0, 2'b01, 32'h110, 2'b00);
    tick();
    drive(1'b0, 2'b11, 32'h114, 2'b00);
    @(negedge clk_i);
    chk("occ3", occupancy_o, 3'd3);
    chk("occ3_ds_rdy", ds_rdy_o, 2'b01);
    tick();
    drive(1'b0, 2'b00, 32'h0, 2'b11);
    @(negedge clk_i);
    chk("partial_occ", occupancy_o, 3'd4);
    tick();
    drive(1'b0, 2'b01, 32'h118, 2'b11);
    @(negedge clk_i);
    chk("partial_pc0", ir_instr0_o.pc, 32'h110);
    chk("partial_pc1", ir_instr1_o.pc, 32'h114);
    chk("partial_occ2", occupancy_o, 3'd2);
    tick();
    drive(1'b0, 2'b00, 32'h0, 2'b01);
    @(negedge clk_i);
    chk("repush_pc0", ir_instr0_o.pc, 32'h118);
    chk("repush_valid", ir_valid_o, 2'b01);
    chk("repush_occ", occupancy_o, 3'd1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 2'b00);
    @(negedge clk_i);
    chk("drained_occ", occupancy_o, 3'd0);
    chk("drained_valid", ir_valid_o, 2'b00);
    tick();
    next_pc = 32'h1000;
    for (int k = 0; k < 20; k++) begin
      sz = q.size();
      pvv = (k % 2 == 0) ? 2'b11 : 2'b01;
      rdy = {sz <= 2, sz <= 3};
      pushm = pvv & rdy;
      npush = int'(pushm[0]) + int'(pushm[1]);
      tmp = q;
      for (int j = 0; j < npush; j++) tmp.push_back(next_pc + 32'(4 * j));
`ifdef IR_FIFO_BYPASS_EN
      vexp = (sz == 0) ? pvv : {sz >= 2, sz >= 1};
`else
      vexp = {sz >= 2, sz >= 1};
`endif
      accv = ((k % 2 == 1) ? 2'b11 : 2'b01) & vexp;
      npop = int'(accv[0]) + int'(accv[1]);
      drive(1'b0, pvv, next_pc, accv);
      @(negedge clk_i);
      chk("wrap_ds_rdy", ds_rdy_o, rdy);
      chk("wrap_valid", ir_valid_o, vexp);
      chk("wrap_occ", occupancy_o, 3'(sz));
      if (vexp[0]) chk("wrap_pc0", ir_instr0_o.pc, tmp[0]);
      if (vexp[1]) chk("wrap_pc1", ir_instr1_o.pc, tmp[1]);
      for (int j = 0; j < npop; j++) void'(tmp.pop_front());
      q = tmp;
      next_pc = next_pc + 32'(4 * npush);
      tick();
    end
    drive(1'b1, 2'b00, 32'h0, 2'b00);
    tick();
    drive(1'b0, 2'b11, 32'h2000, 2'b00);
    tick();
    drive(1'b0, 2'b01, 32'h2008, 2'b00);
    tick();
    drive(1'b1, 2'b11, 32'h3000, 2'b11);
    @(negedge clk_i);
    chk("preflush_occ", occupancy_o, 3'd3);
    chk("preflush_pc0", ir_instr0_o.pc, 32'h2000);
    tick();
    drive(1'b0, 2'b00, 32'h0, 2'b00);
    @(negedge clk_i);
    chk("flush_occ", occupancy_o, 3'd0);
    chk("flush_valid", ir_valid_o, 2'b00);
    chk("flush_ds_rdy", ds_rdy_o, 2'b11);
    tick();
    drive(1'b0, 2'b11, 32'h4000, 2'b01);
    @(negedge clk_i);
`ifdef IR_FIFO_BYPASS_EN
    chk("byp_valid", ir_valid_o, 2'b11);
    chk("byp_pc0", ir_instr0_o.pc, 32'h4000);
`else
    chk("nobyp_valid", ir_valid_o, 2'b00);
`endif
    tick();
    drive(1'b0, 2'b00, 32'h0, 2'b00);
    @(negedge clk_i);
`ifdef IR_FIFO_BYPASS_EN
    chk("byp_occ", occupancy_o, 3'd1);
    chk("byp_rem_pc0", ir_instr0_o.pc, 32'h4004);
`else
    chk("nobyp_occ", occupancy_o, 3'd2);
    chk("nobyp_pc0", ir_instr0_o.pc, 32'h4000);
`endif
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ir_fifo.md
Name: ir_fifo

Overview:
- Two-wide instruction queue between the branch-prediction stage and the instruction-register/decode stage.
- Accepts 0, 1 or 2 predicted instructions per cycle (ir_reg_t, carrying ptaken/ptarget) and presents the oldest two to decode in program order.
- Generates the 2-bit downstream-ready that the predictor consumes as ds_rdy.
- Flushed by EX on redirect.

Parameters:
- Depth, 4, number of ir_reg_t entries; power of two, >= 2.
- PtrW, $clog2(Depth), pointer width (localparam, derived).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- flush_i  input  1  EX redirect/mispredict; discard all contents
- pdt_valid_i  input  2  instruction valid from predictor; legal values 00/01/11
- pdt_instr0_i  input  ir_reg_t  older incoming instruction
- pdt_instr1_i  input  ir_reg_t  younger incoming instruction
- ds_rdy_o  output  2  [0]: >=1 free entry; [1]: >=2 free entries
- ir_valid_o  output  2  [0]: >=1 entry valid; [1]: >=2 entries valid
- ir_instr0_o  output  ir_reg_t  oldest entry
- ir_instr1_o  output  ir_reg_t  second-oldest entry
- ir_accept_i  input  2  decode consumes entries; legal values 00/01/11, and only bits whose ir_valid_o is set
- occupancy_o  output  PtrW+1  current entry count, for perf/debug

Behaviour:
- State: Depth-entry storage array, rd_ptr and wr_ptr (PtrW bits, natural modulo-Depth wrap), count (PtrW+1 bits, 0..Depth).
- Reset (async, rst_ni low):
  - rd_ptr = wr_ptr = count = 0; storage entries = NULL_IR_REG.
  - ds_rdy_o = 2'b11; ir_valid_o = 2'b00; ir_instr*_o = NULL_IR_REG; occupancy_o = 0.
- ds_rdy_o and ir_valid_o are functions of registered count only. There is no combinational path from ir_accept_i to ds_rdy_o or from pdt_valid_i to ir_valid_o (except under the optional feature).
- Push: n_push = popcount(pdt_valid_i & ds_rdy_o).
  - instr0 is written at wr_ptr; instr1 at wr_ptr+1 (wrapping).
  - wr_ptr advances by n_push.
  - pdt_valid_i=11 with ds_rdy_o=01 pushes instr0 only; the predictor holds instr1.
- Pop: n_pop = popcount(ir_accept_i & ir_valid_o). rd_ptr advances by n_pop.
- count_next = count + n_push - n_pop.
  - Simultaneous push and pop in the same cycle is legal at every occupancy.
  - A full queue with a 2-pop still shows ds_rdy_o=00 that cycle; the freed space is visible next cycle.
- Outputs:
  - ir_instr0_o = mem[rd_ptr]; ir_instr1_o = mem[rd_ptr+1].
  - Entry contents are undefined (don't-care) when the matching ir_valid_o bit is 0.
- Flush:
  - When flush_i is high: rd_ptr = wr_ptr = count = 0 next cycle.
  - Pushes and pops in the flush cycle are ignored.
  - Flush has priority over all other events.
  - ds_rdy_o = 11 the following cycle.
- Latency: an instruction pushed in cycle N is visible at the outputs in cycle N+1.
- Order: strict FIFO order; ptaken/ptarget fields pass through unmodified.
- Illegal input 10 on pdt_valid_i or ir_accept_i: flagged by assertion (simulation only). RTL treats it as 00.

Optional Feature:
- Macro: IR_FIFO_BYPASS_EN.
- When defined, and count==0 and flush_i==0:
  - pdt_instr*_i are driven combinationally to ir_instr*_o, and ir_valid_o = pdt_valid_i.
  - Instructions accepted in the same cycle via ir_accept_i are not written to storage. Only the unaccepted remainder is written.
  - Zero-latency pass-through on an empty queue.
- When undefined: the 1-cycle latency defined under Behaviour applies, and ir_valid_o depends only on count.

Decomposition:
- ir_reg_t and NULL_IR_REG already live in super_pkg; reuse them.
- No new typedefs are needed in super_pkg.
- No sub-module. Pointer/count arithmetic and storage are a single always_ff plus output muxing.

Test Plan:
- Reset, then push pdt_valid_i=11 (pc 0x100, 0x104) with ir_accept_i=00 -> next cycle ir_valid_o=11, pc 0x100/0x104, occupancy_o=2, ds_rdy_o=11 (Depth=4).
- Fill with 4 entries, no accept -> ds_rdy_o=00. Then present pdt_valid_i=11 -> nothing written and occupancy_o stays 4. Then accept 11 -> next cycle ds_rdy_o=11, occupancy_o=2.
- occupancy_o=3, present pdt_valid_i=11 with ds_rdy_o=01 -> only instr0 written, occupancy_o=4; instr1 not lost once the predictor re-presents it.
- Wrap-around: push/pop alternating 1 and 2 entries for 20 cycles with incrementing pcs -> output pc sequence strictly monotonic, no drop or duplication across pointer wrap.
- occupancy_o=3, assert flush_i with simultaneous pdt_valid_i=11 and ir_accept_i=11 -> next cycle occupancy_o=0, ir_valid_o=00, ds_rdy_o=11.
- With IR_FIFO_BYPASS_EN: queue empty, pdt_valid_i=11 and ir_accept_i=01 -> same cycle ir_valid_o=11, ir_instr0_o.pc = incoming pc; next cycle occupancy_o=1 holding instr1. Without the macro: same stimulus -> ir_valid_o=00 in that cycle.
